// File: rtl/ej32_obuf_tap.sv
// Snoops byte writes into the eJ32 output window, queues them and streams them out as valid/ready bytes.
// Optional OBUF_CRLF_EN: each 'h0A byte is emitted as 'h0D followed by 'h0A.
module ej32_obuf_tap #(
    parameter int unsigned OBUF  = 'h1400,
    parameter int unsigned OSZ   = 'h600,
    parameter int unsigned ASZ   = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ASZ-1:0]             addr,
    input  logic                       we,
    input  logic [7:0]                 data_o,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic [15:0]                nbytes
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef OBUF_CRLF_EN
        , CR = 2'd2
`endif
    } state_t;

    state_t         state, state_nx;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [7:0]     tx_data_nx;
    logic           match, push, pop, load;
    logic [7:0]     load_byte, next_head;

    // One extra address bit keeps the exclusive window end from wrapping.
    always_comb begin
        match = we
             && ({1'b0, addr} >= (ASZ+1)'(OBUF))
             && ({1'b0, addr} <  (ASZ+1)'(OBUF + OSZ));
    end

    // Next-state, pop decision and next presented byte.
    always_comb begin
        state_nx   = state;
        tx_data_nx = tx_data;
        load       = 1'b0;
        load_byte  = mem[rd_ptr];
        pop        = (state == SEND) && tx_ready;
        push       = match && ((count != CW'(DEPTH)) || pop);
        // After a pop the new head is either already queued or arriving right now.
        next_head  = (count > CW'(1)) ? mem[PW'(rd_ptr + 1'b1)] : data_o;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load      = 1'b1;
                    load_byte = mem[rd_ptr];
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if ((count > CW'(1)) || push) begin
                        load      = 1'b1;
                        load_byte = next_head;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
`ifdef OBUF_CRLF_EN
            CR: begin
                if (tx_ready) begin
                    state_nx   = SEND;
                    tx_data_nx = 8'h0A;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
        if (load) begin
`ifdef OBUF_CRLF_EN
            if (load_byte == 8'h0A) begin
                state_nx   = CR;
                tx_data_nx = 8'h0D;
            end else begin
                state_nx   = SEND;
                tx_data_nx = load_byte;
            end
`else
            state_nx   = SEND;
            tx_data_nx = load_byte;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_nx;
            tx_valid <= (state_nx != IDLE);
            tx_data  <= tx_data_nx;
        end
    end

    // Storage needs no reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            nbytes <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= PW'(wr_ptr + 1'b1);
                nbytes <= 16'(nbytes + 16'd1);
            end
            if (pop) begin
                rd_ptr <= PW'(rd_ptr + 1'b1);
            end
            count <= CW'(count + CW'(push) - CW'(pop));
            if (match && !push) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule
